// File: rtl/k_fifo_pkg.sv
// Shared types and constants for the 2-entry FIFO (k_fifo_2deep_rd).
package k_fifo_pkg;

  localparam int K_FIFO_2DEEP_DEPTH = 2;
  localparam int K_FIFO_PTR_W       = 2;

  // bit0 = entry index, bit1 = wrap bit
  typedef logic [K_FIFO_PTR_W-1:0] ptr_t;

  // occupancy, legal range 0..2
  typedef logic [1:0] cnt_t;

  // pointer advance; rolls 3 -> 0 naturally in 2 bits
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/k_fifo_2deep_mem.sv
// DATA_W x 2 storage: synchronous write, asynchronous read, no reset.
module k_fifo_2deep_mem #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wen,
  input  logic              waddr,
  input  logic [DATA_W-1:0] d,
  input  logic              raddr,
  output logic [DATA_W-1:0] q
);

  logic [1:0][DATA_W-1:0] mem_q;
  logic [1:0][DATA_W-1:0] mem_d;

  // next contents: replace the addressed entry on a write, hold otherwise
  always_comb begin
    mem_d = mem_q;
    if (wen) begin
      mem_d[waddr] = d;
    end else begin
      mem_d = mem_q;
    end
  end

  // storage register; contents are deliberately not reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // asynchronous read port
  always_comb begin
    q = mem_q[raddr];
  end

endmodule

// File: rtl/k_fifo_2deep_rd.sv
// 2-entry FIFO, read-side owner: pointers, occupancy flags, head masking.
// Optional macro K_FIFO_2DEEP_BYPASS_EN: when empty, the input word is
// forwarded combinationally to the output, and is not stored if taken.
module k_fifo_2deep_rd
  import k_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);

  if (DEPTH != K_FIFO_2DEEP_DEPTH) begin : g_depth_bad
    $error("k_fifo_2deep_rd: only DEPTH == 2 is supported");
  end

  ptr_t              wptr_q, wptr_d;
  ptr_t              rptr_q, rptr_d;
  logic              full_s, empty_s;
  logic              push_s, pop_s, wen_s, bypass_s;
  logic [DATA_W-1:0] mem_rdata_s;

  k_fifo_2deep_mem #(
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .wen   (wen_s),
    .waddr (wptr_q[0]),
    .d     (in_data),
    .raddr (rptr_q[0]),
    .q     (mem_rdata_s)
  );

  // occupancy flags derived only from the registered pointers
  always_comb begin
    full_s  = (wptr_q[0] == rptr_q[0]) && (wptr_q[1] != rptr_q[1]);
    empty_s = (wptr_q == rptr_q);
    count   = cnt_t'(wptr_q - rptr_q);
    full    = full_s;
    empty   = empty_s;
  end

  // write-side handshake; held low throughout reset
  always_comb begin
    in_ready = !full_s && !rst;
  end

  // head presentation: masked to zero when nothing is valid
  always_comb begin
    out_valid = 1'b0;
    out_data  = {DATA_W{1'b0}};
`ifdef K_FIFO_2DEEP_BYPASS_EN
    if (empty_s) begin
      out_valid = in_valid && !rst;
      if (in_valid && !rst) begin
        out_data = in_data;
      end else begin
        out_data = {DATA_W{1'b0}};
      end
    end else begin
      out_valid = 1'b1;
      out_data  = mem_rdata_s;
    end
`else
    if (empty_s) begin
      out_valid = 1'b0;
      out_data  = {DATA_W{1'b0}};
    end else begin
      out_valid = 1'b1;
      out_data  = mem_rdata_s;
    end
`endif
  end

  // transfer decode and next pointer values
  always_comb begin
    push_s = in_valid && in_ready;
    // a pop only moves rptr when a stored word is at the head
    pop_s  = out_valid && out_ready && !empty_s;
`ifdef K_FIFO_2DEEP_BYPASS_EN
    bypass_s = empty_s && push_s && out_ready;
`else
    bypass_s = 1'b0;
`endif
    wen_s = push_s && !bypass_s;

    if (wen_s) begin
      wptr_d = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // pointer registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: tb/tb_k_fifo_2deep_rd.sv
// Scoreboard bench for k_fifo_2deep_rd (honours K_FIFO_2DEEP_BYPASS_EN).
module tb_k_fifo_2deep_rd;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;
  logic       full;
  logic       empty;

  int         chk_cnt;
  int         pass_cnt;
  logic [7:0] sb[$];

  k_fifo_2deep_rd #(.DATA_W(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every accepted head word must match the scoreboard front
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        check("sb_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt = 0; pass_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_out_data", out_data, 8'h00);
    check("idle_count", count, 2'd0);

`ifndef K_FIFO_2DEEP_BYPASS_EN
    // no combinational input->output path when empty
    in_valid = 1'b1; in_data = 8'hC3; #1;
    check("nobypass_valid", out_valid, 1'b0);
    check("nobypass_data", out_data, 8'h00);
    in_valid = 1'b0;
`endif

    // single push, one-cycle latency
    in_valid = 1'b1; in_data = 8'hA5; sb.push_back(8'hA5);
    tick();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1'b1);
    check("t1_data", out_data, 8'hA5);
    check("t1_count", count, 2'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_empty", empty, 1'b1);

    // fill, blocked push, stall, drain
    in_valid = 1'b1; in_data = 8'h11; sb.push_back(8'h11);
    tick();
    in_data = 8'h22; sb.push_back(8'h22);
    tick();
    in_data = 8'h33;
    check("t2_full", full, 1'b1);
    check("t2_in_ready", in_ready, 1'b0);
    check("t2_count", count, 2'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_stall_data", out_data, 8'h11);
      check("t2_stall_valid", out_valid, 1'b1);
      check("t2_stall_count", count, 2'd2);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("t2_empty", empty, 1'b1);
    check("t2_count0", count, 2'd0);

    // streaming at occupancy 1 across pointer wrap
    in_valid = 1'b1; in_data = 8'h00; sb.push_back(8'h00);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      in_data = 8'(i); sb.push_back(8'(i));
      tick();
      check("t3_count", count, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("t3_empty", empty, 1'b1);

    // push and pop together while full
    in_valid = 1'b1; in_data = 8'h44; sb.push_back(8'h44);
    tick();
    in_data = 8'h55; sb.push_back(8'h55);
    tick();
    in_data = 8'h66; sb.push_back(8'h66); out_ready = 1'b1;
    check("t4_in_ready", in_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    check("t4_count1", count, 2'd1);
    check("t4_head", out_data, 8'h55);
    tick();
    in_valid = 1'b0;
    check("t4_count2", count, 2'd2);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("t4_empty", empty, 1'b1);

    // asynchronous reset mid-cycle while full
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_data = 8'h88;
    tick();
    in_valid = 1'b0;
    check("t5_pre_count", count, 2'd2);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_data", out_data, 8'h00);
    check("t5_rst_count", count, 2'd0);
    check("t5_rst_full", full, 1'b0);
    check("t5_rst_in_ready", in_ready, 1'b0);
    sb.delete();
    #3 rst = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 8'h5A; sb.push_back(8'h5A);
    tick();
    in_valid = 1'b0;
    check("t5_data", out_data, 8'h5A);
    check("t5_count", count, 2'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef K_FIFO_2DEEP_BYPASS_EN
    // pass-through when empty and consumer ready
    in_valid = 1'b1; in_data = 8'h7E; out_ready = 1'b1; sb.push_back(8'h7E);
    #1;
    check("t6_bp_valid", out_valid, 1'b1);
    check("t6_bp_data", out_data, 8'h7E);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t6_bp_count", count, 2'd0);
    // consumer stalled: word is stored
    in_valid = 1'b1; in_data = 8'h7E; sb.push_back(8'h7E);
    tick();
    in_valid = 1'b0;
    check("t6_st_count", count, 2'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
